// File: rtl/siren_pkg.sv
// Shared definitions for the siren sweep generator: mode encodings, ALT phase states, PWM width.
package siren_pkg;

  localparam logic [2:0] MODE_SILENT = 3'd0;
  localparam logic [2:0] MODE_FIXED  = 3'd1;
  localparam logic [2:0] MODE_FAST   = 3'd2;
  localparam logic [2:0] MODE_SLOW   = 3'd3;
  localparam logic [2:0] MODE_ALT    = 3'd4;
  localparam logic [2:0] MODE_RAMP   = 3'd5;

  typedef enum logic {
    FAST_PH = 1'b0,
    SLOW_PH = 1'b1
  } alt_state_t;

  localparam int unsigned PWM_W = 4;

  function automatic logic mode_active(input logic [2:0] m);
    return (m >= MODE_FIXED) && (m <= MODE_RAMP);
  endfunction

endpackage

// File: rtl/siren_sweep_gen_tri.sv
// Sweep modulator: prescaler, phase counter and triangle/ramp shaping for siren_sweep_gen.
module sweep_tri_gen #(
  parameter int unsigned SWEEP_W    = 7,
  parameter int unsigned FAST_SHIFT = 15,
  parameter int unsigned SLOW_SHIFT = 18
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               slow_sel,
  input  logic               ramp_sel,
  input  logic               clr,
  output logic [SWEEP_W-1:0] sweep,
  output logic               wrap
);

  logic [SLOW_SHIFT-1:0] presc;
  logic [SWEEP_W:0]      phase;
  logic                  tick;

  always_comb begin
    tick = slow_sel ? (&presc) : (&presc[FAST_SHIFT-1:0]);
    wrap = !clr && tick && (&phase);
    if (ramp_sel)
      sweep = phase[SWEEP_W-1:0];
    else
      sweep = phase[SWEEP_W] ? phase[SWEEP_W-1:0] : ~phase[SWEEP_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
      phase <= '0;
    end else if (clr) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= presc + SLOW_SHIFT'(1);
      if (tick)
        phase <= phase + (SWEEP_W+1)'(1);
    end
  end

endmodule

// File: rtl/siren_sweep_gen.sv
// Multi-mode tone/siren generator with glitch-free divider reloads.
// Optional SIREN_VOLUME_EN adds a 4-bit volume input gating SPEAKER with a PWM counter.
module siren_sweep_gen
  import siren_pkg::*;
#(
  parameter int unsigned DIV_W      = 15,
  parameter int unsigned SWEEP_W    = 7,
  parameter int unsigned SWEEP_LSB  = 6,
  parameter int unsigned DIV_OFFSET = 8192,
  parameter int unsigned FAST_SHIFT = 15,
  parameter int unsigned SLOW_SHIFT = 18
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] base_div,
`ifdef SIREN_VOLUME_EN
  input  logic [3:0]       volume,
`endif
  output logic             SPEAKER,
  output logic             USBPU,
  output logic             tone_edge,
  output logic             alt_slow
);

  localparam longint unsigned MAX_DIV =
    longint'(DIV_OFFSET) + (((64'(1) << SWEEP_W) - 64'(1)) << SWEEP_LSB);

  generate
    if (MAX_DIV >= (64'(1) << DIV_W)) begin : g_div_range_bad
      $error("siren_sweep_gen: DIV_OFFSET plus shifted sweep overflows DIV_W");
    end
  endgenerate

  localparam logic [DIV_W-1:0] OFFS = DIV_W'(DIV_OFFSET);

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   target;
  logic [SWEEP_W-1:0] sweep;
  logic               wrap;
  logic               tone_q;
  logic [2:0]         mode_q;
  logic               act_q;
  logic               act, chg, clr, slow_sel, ramp_sel;
  alt_state_t         alt_st;

  assign USBPU = 1'b0;

  // FIXED with a zero divider is folded into the silent path rather than toggling every clock
  always_comb begin
    act      = en && mode_active(mode) && !(mode == MODE_FIXED && base_div == '0);
    chg      = act_q && (mode != mode_q);
    clr      = !act || chg;
    slow_sel = (mode == MODE_SLOW) || (mode == MODE_RAMP) ||
               ((mode == MODE_ALT) && (alt_st == SLOW_PH));
    ramp_sel = (mode == MODE_RAMP);
    if (mode == MODE_FIXED)
      target = base_div;
    else
      target = OFFS + (DIV_W'(sweep) << SWEEP_LSB);
  end

  sweep_tri_gen #(
    .SWEEP_W    (SWEEP_W),
    .FAST_SHIFT (FAST_SHIFT),
    .SLOW_SHIFT (SLOW_SHIFT)
  ) u_sweep (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .slow_sel (slow_sel),
    .ramp_sel (ramp_sel),
    .clr      (clr),
    .sweep    (sweep),
    .wrap     (wrap)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt   <= '0;
      tone_q    <= 1'b0;
      tone_edge <= 1'b0;
      alt_st    <= FAST_PH;
      alt_slow  <= 1'b0;
      mode_q    <= MODE_SILENT;
      act_q     <= 1'b0;
    end else begin
      mode_q <= mode;
      act_q  <= act;
      if (!act) begin
        div_cnt   <= '0;
        tone_q    <= 1'b0;
        tone_edge <= 1'b0;
        alt_st    <= FAST_PH;
        alt_slow  <= 1'b0;
      end else begin
        if (div_cnt == '0) begin
          div_cnt   <= target;
          tone_q    <= ~tone_q;
          tone_edge <= 1'b1;
        end else begin
          div_cnt   <= div_cnt - DIV_W'(1);
          tone_edge <= 1'b0;
        end
        // a mode change outranks a coincident wrap
        if (chg || mode != MODE_ALT) begin
          alt_st   <= FAST_PH;
          alt_slow <= 1'b0;
        end else if (wrap) begin
          alt_st   <= (alt_st == FAST_PH) ? SLOW_PH : FAST_PH;
          alt_slow <= (alt_st == FAST_PH);
        end
      end
    end
  end

`ifdef SIREN_VOLUME_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign SPEAKER = tone_q & ((volume == '1) | (pwm_cnt < volume));
`else
  assign SPEAKER = tone_q;
`endif

endmodule
